// File: rtl/prog_count_stack.sv
// Program counter with absolute/relative load, stall, and return-address stack.
// PC and stack updates appear one cycle after the command; stall freezes all state.
module prog_count_stack #(
  parameter int ADDR_W      = 4,
  parameter int SEL_W       = 8,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_ADDR  = 0,
  localparam int SP_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              incPC,
  input  logic              loadPC,
  input  logic              relPC,
  input  logic              call,
  input  logic              ret,
  input  logic              clr_err,
  input  logic [SEL_W-1:0]  selPC,
  output logic [ADDR_W-1:0] ins_mem,
  output logic [SP_W-1:0]   sp,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              ovf_err,
  output logic              unf_err
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic              push_vld;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;
  logic [ADDR_W-1:0] push_dat;
  logic [ADDR_W-1:0] sel_lo;
  logic [ADDR_W-1:0] pc_inc;

  assign sel_lo      = selPC[ADDR_W-1:0];
  assign pc_inc      = pc_q + ADDR_W'(1);
  assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);
  assign push_idx    = IDX_W'(sp_q);
  assign pop_idx     = IDX_W'(sp_q - SP_W'(1));
  assign push_dat    = pc_inc;

  // Upper selPC bits only matter to the datapath; they are dropped here.
  generate
    if (SEL_W > ADDR_W) begin : g_sel_hi
      logic unused_sel_hi;
      assign unused_sel_hi = ^selPC[SEL_W-1:ADDR_W];
    end
  endgenerate

  always_comb begin
    pc_d     = pc_q;
    sp_d     = sp_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    push_vld = 1'b0;
    if (!stall) begin
      // Clear first so a same-cycle error set overrides it.
      if (clr_err) begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
      if (ret) begin
        if (!stack_empty) begin
          pc_d = stack_q[pop_idx];
          sp_d = sp_q - SP_W'(1);
        end else begin
          unf_d = 1'b1;
        end
      end else if (call) begin
        if (!stack_full) begin
          push_vld = 1'b1;
          pc_d     = sel_lo;
          sp_d     = sp_q + SP_W'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end else if (loadPC) begin
        pc_d = relPC ? (pc_q + sel_lo) : sel_lo;
      end else if (incPC) begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= ADDR_W'(RESET_ADDR);
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Entries above sp are never read, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (push_vld) begin
      stack_q[push_idx] <= push_dat;
    end
  end

  assign ins_mem = pc_q;
  assign sp      = sp_q;
  assign ovf_err = ovf_q;
  assign unf_err = unf_q;

endmodule

// File: tb/tb_prog_count_stack.sv
// Directed bench for prog_count_stack with default parameters (ADDR_W=4, DEPTH=4).
module tb_prog_count_stack;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stall, incPC, loadPC, relPC, call, ret, clr_err;
  logic [7:0] selPC;
  logic [3:0] ins_mem;
  logic [2:0] sp;
  logic       stack_full, stack_empty, ovf_err, unf_err;

  int errors = 0;
  int checks = 0;

  prog_count_stack #(
    .ADDR_W(4), .SEL_W(8), .STACK_DEPTH(4), .RESET_ADDR(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .incPC(incPC), .loadPC(loadPC),
    .relPC(relPC), .call(call), .ret(ret), .clr_err(clr_err), .selPC(selPC),
    .ins_mem(ins_mem), .sp(sp), .stack_full(stack_full), .stack_empty(stack_empty),
    .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    stall = 0; incPC = 0; loadPC = 0; relPC = 0; call = 0; ret = 0; clr_err = 0;
    selPC = 8'h00;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic ld_abs(input logic [7:0] v);
    loadPC = 1; selPC = v; cyc();
  endtask

  task automatic ld_rel(input logic [7:0] v);
    loadPC = 1; relPC = 1; selPC = v; cyc();
  endtask

  task automatic do_call(input logic [7:0] v);
    call = 1; selPC = v; cyc();
  endtask

  task automatic do_ret();
    ret = 1; cyc();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #12;
    chk("rst_pc", 32'(ins_mem), 0);
    chk("rst_sp", 32'(sp), 0);
    chk("rst_empty", 32'(stack_empty), 1);
    chk("rst_full", 32'(stack_full), 0);
    chk("rst_ovf", 32'(ovf_err), 0);
    chk("rst_unf", 32'(unf_err), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Increment through full wrap, then stall holds.
    for (int i = 1; i <= 16; i++) begin
      incPC = 1; cyc();
      chk("inc", 32'(ins_mem), 32'(i % 16));
    end
    stall = 1; incPC = 1; cyc();
    chk("stall_hold", 32'(ins_mem), 0);
    incPC = 1; cyc();
    chk("inc_after_stall", 32'(ins_mem), 1);

    // Absolute and relative loads.
    ld_abs(8'h05); chk("abs5", 32'(ins_mem), 5);
    ld_rel(8'hFE); chk("rel_m2", 32'(ins_mem), 3);
    ld_abs(8'h0E); chk("abs14", 32'(ins_mem), 14);
    ld_rel(8'h03); chk("rel_wrap", 32'(ins_mem), 1);
    ld_abs(8'hA7); chk("abs_hi_ignored", 32'(ins_mem), 7);

    // Nested call/return.
    ld_abs(8'h02);
    do_call(8'h09); chk("call1_pc", 32'(ins_mem), 9); chk("call1_sp", 32'(sp), 1);
    do_call(8'h0C); chk("call2_pc", 32'(ins_mem), 12); chk("call2_sp", 32'(sp), 2);
    do_ret(); chk("ret1_pc", 32'(ins_mem), 10); chk("ret1_sp", 32'(sp), 1);
    do_ret(); chk("ret2_pc", 32'(ins_mem), 3); chk("ret2_empty", 32'(stack_empty), 1);

    // Asynchronous reset mid-run with two entries stacked.
    do_call(8'h05); do_call(8'h07);
    chk("pre_rst_sp", 32'(sp), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", 32'(ins_mem), 0);
    chk("arst_sp", 32'(sp), 0);
    chk("arst_empty", 32'(stack_empty), 1);
    chk("arst_errs", 32'({ovf_err, unf_err}), 0);
    #2 rst_n = 1'b1;
    cyc();

    // Fill stack, overflow, drain, underflow.
    ld_abs(8'h01);
    do_call(8'h02); do_call(8'h03); do_call(8'h04); do_call(8'h06);
    chk("fill_sp", 32'(sp), 4);
    chk("fill_full", 32'(stack_full), 1);
    do_call(8'h09);
    chk("ovf_pc", 32'(ins_mem), 6);
    chk("ovf_sp", 32'(sp), 4);
    chk("ovf_flag", 32'(ovf_err), 1);
    do_ret(); chk("drain1", 32'(ins_mem), 5);
    do_ret(); chk("drain2", 32'(ins_mem), 4);
    do_ret(); chk("drain3", 32'(ins_mem), 3);
    do_ret(); chk("drain4", 32'(ins_mem), 2);
    chk("drain_sp", 32'(sp), 0);
    chk("ovf_sticky", 32'(ovf_err), 1);
    do_ret();
    chk("unf_pc", 32'(ins_mem), 2);
    chk("unf_flag", 32'(unf_err), 1);
    stall = 1; clr_err = 1; cyc();
    chk("clr_stalled", 32'({ovf_err, unf_err}), 32'h3);
    clr_err = 1; cyc();
    chk("clr_errs", 32'({ovf_err, unf_err}), 0);

    // Priority: ret beats call/loadPC/incPC; set beats clear.
    ld_abs(8'h08);
    do_call(8'h03);
    chk("pri_call", 32'(ins_mem), 3);
    ret = 1; call = 1; loadPC = 1; incPC = 1; selPC = 8'h0F; cyc();
    chk("pri_ret_pc", 32'(ins_mem), 9);
    chk("pri_ret_sp", 32'(sp), 0);
    ret = 1; clr_err = 1; cyc();
    chk("set_over_clr", 32'(unf_err), 1);
    chk("set_over_clr_pc", 32'(ins_mem), 9);

    // Return address wraps at the top of the address space.
    ld_abs(8'h0F);
    do_call(8'h04);
    do_ret();
    chk("push_wrap", 32'(ins_mem), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
